// File: rtl/fifo_wr_pkt_ctrl_if.sv
// Ingress AXI-Stream beat bundle for the Ethernet RX FIFO write-side packet controller.
// There is no tready: the MAC receive path cannot be stalled.
interface fifo_wr_pkt_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser
    );

    modport slave (
        input tdata,
        input tvalid,
        input tlast,
        input tuser
    );
endinterface

// File: rtl/fifo_wr_pkt_ctrl.sv
// Write-side packet controller for the Ethernet RX async FIFO: commits good frames, rolls back bad,
// oversize or overflowing ones. Statistics counters exist only when FIFO_WR_CTRL_STATS_EN is defined.
module fifo_wr_pkt_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_FRAME_BEATS = 1518
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fifo_wr_pkt_ctrl_if.slave     s_axis,
    input  logic                  fifo_full,
    input  logic                  fifo_almost_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_latch_addr,
    output logic                  fifo_drop_pckt,
    output logic [31:0]           good_frames,
    output logic [31:0]           dropped_frames,
    output logic [31:0]           overflow_frames
);

    localparam int                BCNT_W  = $clog2(MAX_FRAME_BEATS + 1);
    localparam logic [BCNT_W-1:0] MAX_CNT = BCNT_W'(MAX_FRAME_BEATS);
    localparam logic [BCNT_W-1:0] ONE_CNT = BCNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [BCNT_W-1:0]     bcnt_r;
    logic [BCNT_W-1:0]     bcnt_nxt_s;
    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  last_r;
    logic                  user_r;
    logic                  wr_en_s;
    logic                  latch_s;
    logic                  drop_s;

    // Input stage: every decision is taken on the registered beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            last_r  <= 1'b0;
            user_r  <= 1'b0;
        end else begin
            valid_r <= s_axis.tvalid;
            data_r  <= s_axis.tdata;
            last_r  <= s_axis.tlast;
            user_r  <= s_axis.tuser;
        end
    end

    // State and beat-count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            bcnt_r  <= {BCNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            bcnt_r  <= bcnt_nxt_s;
        end
    end

    // Next-state and write-port control for the registered beat.
    always_comb begin
        state_nxt_s = state_r;
        bcnt_nxt_s  = bcnt_r;
        wr_en_s     = 1'b0;
        latch_s     = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!valid_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (fifo_almost_full || fifo_full) begin
                    // Not enough room to start a frame: reject it whole.
                    if (last_r) begin
                        drop_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end else begin
                    wr_en_s    = 1'b1;
                    bcnt_nxt_s = ONE_CNT;
                    if (last_r) begin
                        latch_s     = ~user_r;
                        drop_s      = user_r;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (!valid_r) begin
                    state_nxt_s = ST_WRITE;
                end else if (fifo_full || (bcnt_r == MAX_CNT)) begin
                    if (last_r) begin
                        drop_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end else begin
                    wr_en_s    = 1'b1;
                    bcnt_nxt_s = bcnt_r + ONE_CNT;
                    if (last_r) begin
                        // A bad frame is still written; the rollback overrides that write.
                        latch_s     = ~user_r;
                        drop_s      = user_r;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WRITE;
                    end
                end
            end
            ST_DROP: begin
                if (valid_r && last_r) begin
                    drop_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                bcnt_nxt_s  = {BCNT_W{1'b0}};
            end
        endcase
    end

    assign fifo_wr_en      = wr_en_s;
    assign fifo_wr_data    = data_r;
    assign fifo_latch_addr = latch_s;
    assign fifo_drop_pckt  = drop_s;

`ifdef FIFO_WR_CTRL_STATS_EN
    // Frame statistics; a drop without a write is always a full/oversize/reject drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            good_frames     <= 32'd0;
            dropped_frames  <= 32'd0;
            overflow_frames <= 32'd0;
        end else begin
            if (latch_s) begin
                good_frames <= good_frames + 32'd1;
            end
            if (drop_s) begin
                dropped_frames <= dropped_frames + 32'd1;
            end
            if (drop_s && !wr_en_s) begin
                overflow_frames <= overflow_frames + 32'd1;
            end
        end
    end
`else
    assign good_frames     = 32'd0;
    assign dropped_frames  = 32'd0;
    assign overflow_frames = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_pkt_ctrl.sv
// Scoreboard bench for fifo_wr_pkt_ctrl: directed frames push expected write-port events,
// a forked monitor pops and compares them whenever the DUT drives a write, commit or drop.
module tb_fifo_wr_pkt_ctrl;

    localparam int DW   = 8;
    localparam int MAXB = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          fifo_full;
    logic          fifo_almost_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_latch_addr;
    logic          fifo_drop_pckt;
    logic [31:0]   good_frames;
    logic [31:0]   dropped_frames;
    logic [31:0]   overflow_frames;

    fifo_wr_pkt_ctrl_if #(.DATA_WIDTH(DW)) s_axis ();

    fifo_wr_pkt_ctrl #(
        .DATA_WIDTH      (DW),
        .MAX_FRAME_BEATS (MAXB)
    ) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s_axis           (s_axis),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_latch_addr  (fifo_latch_addr),
        .fifo_drop_pckt   (fifo_drop_pckt),
        .good_frames      (good_frames),
        .dropped_frames   (dropped_frames),
        .overflow_frames  (overflow_frames)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          wr;
        logic          latch;
        logic          drop;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   exp_good  = 0;
    int   exp_drop  = 0;
    int   exp_ovf   = 0;
    bit   pend_full = 1'b0;
    bit   pend_af   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pops one expected event for every cycle in which the DUT drives the write port.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && (fifo_wr_en || fifo_latch_addr || fifo_drop_pckt)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {29'd0, fifo_wr_en, fifo_latch_addr, fifo_drop_pckt}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_en", 32'(fifo_wr_en), 32'(e.wr));
                    check("latch_addr", 32'(fifo_latch_addr), 32'(e.latch));
                    check("drop_pckt", 32'(fifo_drop_pckt), 32'(e.drop));
                    if (e.wr) begin
                        check("wr_data", 32'(fifo_wr_data), 32'(e.data));
                    end
                end
            end
        end
    endtask

    // Drives one beat; full/af take effect in the cycle the DUT processes this beat.
    task automatic beat(input logic [DW-1:0] d, input bit last, input bit user, input bit full,
                        input bit af, input bit ewr, input bit elatch, input bit edrop, input bit eovf);
        @(posedge clk);
        #1;
        fifo_full        = pend_full;
        fifo_almost_full = pend_af;
        s_axis.tvalid    = 1'b1;
        s_axis.tdata     = d;
        s_axis.tlast     = last;
        s_axis.tuser     = user;
        pend_full        = full;
        pend_af          = af;
        if (ewr || elatch || edrop) begin
            exp_q.push_back('{data: d, wr: ewr, latch: elatch, drop: edrop});
        end
        if (elatch) exp_good++;
        if (edrop) begin
            exp_drop++;
            if (eovf) exp_ovf++;
        end
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
        fifo_full        = pend_full;
        fifo_almost_full = pend_af;
        s_axis.tvalid    = 1'b0;
        s_axis.tlast     = 1'b0;
        s_axis.tuser     = 1'b0;
        pend_full        = 1'b0;
        pend_af          = 1'b0;
    endtask

    // stop: first beat that must not be written (0 = all written); full_from: first beat seeing fifo_full.
    task automatic frame(input int n, input logic [DW-1:0] base, input bit user, input int stop,
                         input int full_from, input bit af_first, input int gap_after);
        for (int i = 1; i <= n; i++) begin
            bit last;
            bit wr;
            last = (i == n);
            wr   = (stop == 0) || (i < stop);
            beat(base + DW'(i), last, last ? user : 1'b1,
                 (full_from != 0) && (i >= full_from), af_first && (i == 1),
                 wr, last && (stop == 0) && !user, last && ((stop != 0) || user), stop != 0);
            if (i == gap_after) begin
                gap();
                gap();
            end
        end
    endtask

    task automatic check_counters(input string tag);
        int eg;
        int ed;
        int eo;
`ifdef FIFO_WR_CTRL_STATS_EN
        eg = exp_good;
        ed = exp_drop;
        eo = exp_ovf;
`else
        eg = 0;
        ed = 0;
        eo = 0;
`endif
        repeat (3) gap();
        @(negedge clk);
        check({tag, "_good_frames"}, good_frames, 32'(eg));
        check({tag, "_dropped_frames"}, dropped_frames, 32'(ed));
        check({tag, "_overflow_frames"}, overflow_frames, 32'(eo));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
        check({tag, "_latch"}, 32'(fifo_latch_addr), 32'd0);
        check({tag, "_drop"}, 32'(fifo_drop_pckt), 32'd0);
        check({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
        check({tag, "_good"}, good_frames, 32'd0);
        check({tag, "_dropped"}, dropped_frames, 32'd0);
        check({tag, "_overflow"}, overflow_frames, 32'd0);
    endtask

    initial begin
        reset_n          = 1'b0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        s_axis.tvalid    = 1'b1;
        s_axis.tdata     = 8'hA5;
        s_axis.tlast     = 1'b1;
        s_axis.tuser     = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        reset_n       = 1'b1;

        // 64-beat good frame: exactly MAX_FRAME_BEATS, so it commits.
        frame(64, 8'h00, 1'b0, 0, 0, 1'b0, 0);
        check_counters("good64");

        // 10-beat bad frame with an idle gap inside: written, then rolled back.
        frame(10, 8'h40, 1'b1, 0, 0, 1'b0, 3);
        check_counters("bad10");

        // fifo_full from beat 5 of 20: four writes, drop on beat 20.
        frame(20, 8'h60, 1'b0, 5, 5, 1'b0, 0);
        check_counters("full20");

        // almost_full on a 1-beat frame, then back-to-back 1-beat good, 3-beat reject, 1-beat bad.
        frame(1, 8'h90, 1'b0, 1, 0, 1'b1, 0);
        frame(1, 8'h91, 1'b0, 0, 0, 1'b0, 0);
        frame(3, 8'h92, 1'b0, 1, 0, 1'b1, 0);
        frame(1, 8'h96, 1'b1, 0, 0, 1'b0, 0);
        check_counters("afull");

        // Oversize 65-beat frame back-to-back with a 64-beat good frame.
        frame(65, 8'h10, 1'b0, 65, 0, 1'b0, 0);
        frame(64, 8'h70, 1'b0, 0, 0, 1'b0, 0);
        check_counters("oversize");

        // Reset while beat 7 of a frame is in flight; six beats were already written.
        for (int i = 1; i <= 7; i++) begin
            beat(8'h80 + DW'(i), 1'b0, 1'b0, 1'b0, 1'b0, i < 7, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #3;
        reset_n       = 1'b0;
        s_axis.tvalid = 1'b0;
        pend_full     = 1'b0;
        pend_af       = 1'b0;
        exp_good      = 0;
        exp_drop      = 0;
        exp_ovf       = 0;
        repeat (2) @(negedge clk);
        check_quiet("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        frame(8, 8'hC0, 1'b0, 0, 0, 1'b0, 0);
        check_counters("after_reset");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
